// File: rtl/mem_port_arbiter.sv
// Burst arbiter sharing one memory port between I-cache and D-cache.
// Define ARB_RR_EN for round-robin tie-breaking; default is D-over-I priority.
module mem_port_arbiter #(
  parameter int DW          = 32,
  parameter int AW          = 32,
  parameter int BLOCK_WORDS = 4,
  localparam int OFF        = $clog2(BLOCK_WORDS)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_req,
  input  logic [AW-1:0]  i_addr,
  output logic [DW-1:0]  i_rdata,
  output logic           i_valid,
  output logic           i_done,
  input  logic           d_req,
  input  logic           d_we,
  input  logic [AW-1:0]  d_addr,
  input  logic [DW-1:0]  d_wdata,
  output logic [DW-1:0]  d_rdata,
  output logic           d_valid,
  output logic           d_done,
  output logic [OFF-1:0] beat_idx,
  output logic           mem_en,
  output logic           mem_we,
  output logic [AW-1:0]  mem_addr,
  output logic [DW-1:0]  mem_wdata,
  input  logic [DW-1:0]  mem_rdata,
  input  logic           mem_ready
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  localparam logic [OFF-1:0] LAST = OFF'(BLOCK_WORDS - 1);

  state_t         state_q, state_d;
  logic [OFF-1:0] beat_q, beat_d;
  logic           own_d_q, own_d_d;
  logic [DW-1:0]  ird_q, drd_q;
  logic           iv_q, dv_q;
  logic           gnt_d;
  logic           wr;
  logic           rd_fire;
  logic [AW-1:0]  own_addr;

`ifdef ARB_RR_EN
  logic rr_last_q, rr_last_d;
`endif

  // gnt_d: 1 grants the D-cache, 0 the I-cache
  always_comb begin
    gnt_d = d_req;
`ifdef ARB_RR_EN
    if (i_req && d_req) gnt_d = !rr_last_q;
`endif
  end

  assign wr       = own_d_q && d_we;
  assign own_addr = own_d_q ? d_addr : i_addr;
  assign rd_fire  = (state_q == S_BUSY) && mem_ready && !wr;

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    own_d_d   = own_d_q;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    i_done    = 1'b0;
    d_done    = 1'b0;
`ifdef ARB_RR_EN
    rr_last_d = rr_last_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (i_req || d_req) begin
          own_d_d = gnt_d;
          beat_d  = '0;
          state_d = S_BUSY;
`ifdef ARB_RR_EN
          rr_last_d = gnt_d;
`endif
        end
      end
      S_BUSY: begin
        mem_en    = 1'b1;
        mem_we    = wr;
        mem_addr  = {own_addr[AW-1:OFF], beat_q};
        mem_wdata = d_wdata;
        if (mem_ready) begin
          if (beat_q == LAST) state_d = S_DONE;
          else beat_d = beat_q + 1'b1;
        end
      end
      S_DONE: begin
        i_done  = !own_d_q;
        d_done  = own_d_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      own_d_q <= 1'b1;
      ird_q   <= '0;
      drd_q   <= '0;
      iv_q    <= 1'b0;
      dv_q    <= 1'b0;
`ifdef ARB_RR_EN
      rr_last_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      own_d_q <= own_d_d;
      iv_q    <= rd_fire && !own_d_q;
      dv_q    <= rd_fire && own_d_q;
      if (rd_fire && !own_d_q) ird_q <= mem_rdata;
      if (rd_fire && own_d_q) drd_q <= mem_rdata;
`ifdef ARB_RR_EN
      rr_last_q <= rr_last_d;
`endif
    end
  end

  assign i_rdata  = ird_q;
  assign d_rdata  = drd_q;
  assign i_valid  = iv_q;
  assign d_valid  = dv_q;
  assign beat_idx = beat_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: burst table plus
// reset/arbitration sequences, with an address/data scoreboard.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic [31:0] i_rdata;
  logic        i_valid, i_done;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_valid, d_done;
  logic [1:0]  beat_idx;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ready = 1'b1;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign d_wdata   = 32'hD0 + {30'b0, beat_idx};
  assign mem_rdata = 32'hA0 + mem_addr - 32'h44;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata),
    .i_valid(i_valid), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_rdata(d_rdata),
    .d_valid(d_valid), .d_done(d_done),
    .beat_idx(beat_idx), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wd;
  } beat_t;

  beat_t       exp_beat[$];
  logic [31:0] exp_i[$];
  logic [31:0] exp_d[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] memd(input logic [31:0] a);
    return 32'hA0 + a - 32'h44;
  endfunction

  task automatic push_burst(input bit is_d, input bit we,
                            input logic [31:0] addr);
    for (int i = 0; i < 4; i++) begin
      beat_t b;
      b.addr = {addr[31:2], 2'(i)};
      b.we   = we;
      b.wd   = 32'hD0 + i;
      exp_beat.push_back(b);
      if (!we) begin
        if (is_d) exp_d.push_back(memd(b.addr));
        else exp_i.push_back(memd(b.addr));
      end
    end
  endtask

  task automatic flush();
    exp_beat.delete();
    exp_i.delete();
    exp_d.delete();
  endtask

  // scoreboard monitor, samples mid-cycle
  always begin
    @(negedge clk);
    #2;
    if (!rst) begin
      if (mem_en && mem_ready) begin
        if (exp_beat.size() == 0) begin
          chk("unexpected_beat_addr", mem_addr, 32'hFFFF_FFFF);
        end else begin
          beat_t b;
          b = exp_beat.pop_front();
          chk("mem_addr", mem_addr, b.addr);
          chk("mem_we", {31'b0, mem_we}, {31'b0, b.we});
          if (b.we) chk("mem_wdata", mem_wdata, b.wd);
        end
      end
      if (i_valid) begin
        if (exp_i.size() == 0) chk("unexpected_i_valid", i_rdata, 32'hFFFF_FFFF);
        else chk("i_rdata", i_rdata, exp_i.pop_front());
      end
      if (d_valid) begin
        if (exp_d.size() == 0) chk("unexpected_d_valid", d_rdata, 32'hFFFF_FFFF);
        else chk("d_rdata", d_rdata, exp_d.pop_front());
      end
    end
  end

  task automatic run_burst(input bit is_d, input bit we,
                           input logic [31:0] addr, input int stall,
                           output int cyc, output int hold);
    logic [31:0] hold_a;
    int k;
    hold_a = {addr[31:2], 2'b01};
    cyc  = -1;
    hold = 0;
    @(negedge clk);
    push_burst(is_d, we, addr);
    if (is_d) begin
      d_addr = addr;
      d_we   = we;
      d_req  = 1'b1;
    end else begin
      i_addr = addr;
      i_req  = 1'b1;
    end
    k = 0;
    while (cyc < 0 && k < 200) begin
      k++;
      @(negedge clk);
      mem_ready = !(stall > 0 && k >= 2 && k < 2 + stall);
      #2;
      if (mem_en && mem_addr == hold_a) hold++;
      if ((is_d && i_done) || (!is_d && d_done))
        chk("wrong_done", {30'b0, d_done, i_done}, {30'b0, is_d, !is_d});
      if ((is_d && d_done) || (!is_d && i_done)) begin
        cyc   = k;
        i_req = 1'b0;
        d_req = 1'b0;
      end
    end
    mem_ready = 1'b1;
  endtask

  task automatic wait_done(output bit got_d, output int cyc);
    got_d = 1'b0;
    cyc   = -1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      #2;
      if (i_done || d_done) begin
        got_d = d_done;
        cyc   = k;
        break;
      end
    end
  endtask

  task automatic idle_check(input string nm);
    chk({nm, "_mem_en"}, {31'b0, mem_en}, 32'h0);
    chk({nm, "_beat_idx"}, {30'b0, beat_idx}, 32'h0);
    chk({nm, "_vd"}, {28'b0, i_valid, d_valid, i_done, d_done}, 32'h0);
    chk({nm, "_mem_addr"}, mem_addr, 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst   = 1'b1;
    i_req = 1'b0;
    d_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    flush();
  endtask

  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    int          stall;
    int          exp_cyc;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int cyc, hold, c1, c2;
    bit got_d, exp_own_d;
    bit last_d;

    vecs[0] = '{1'b0, 1'b0, 32'h0000_0045, 0, 5};
    vecs[1] = '{1'b1, 1'b1, 32'h0000_0100, 0, 5};
    vecs[2] = '{1'b1, 1'b1, 32'h0000_0100, 3, 8};
    vecs[3] = '{1'b1, 1'b0, 32'h0000_0203, 0, 5};
    vecs[4] = '{1'b0, 1'b0, 32'hFFFF_FFFF, 2, 7};
    vecs[5] = '{1'b1, 1'b0, 32'h0000_0046, 1, 6};

    do_reset();
    #2;
    idle_check("reset");

    foreach (vecs[v]) begin
      run_burst(vecs[v].is_d, vecs[v].we, vecs[v].addr,
                vecs[v].stall, cyc, hold);
      chk($sformatf("burst%0d_done_cycle", v), cyc, vecs[v].exp_cyc);
      chk($sformatf("burst%0d_beat1_hold", v), hold, 1 + vecs[v].stall);
    end

    // reset in the middle of a burst at beat 2
    @(negedge clk);
    push_burst(1'b1, 1'b0, 32'h200);
    d_addr = 32'h200;
    d_we   = 1'b0;
    d_req  = 1'b1;
    got_d  = 1'b0;
    for (int k = 0; k < 20 && !got_d; k++) begin
      @(negedge clk);
      if (beat_idx == 2'd2) got_d = 1'b1;
    end
    chk("midburst_reached_beat2", {31'b0, got_d}, 32'h1);
    rst   = 1'b1;
    d_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    flush();
    #2;
    idle_check("midreset");
    @(negedge clk);
    #2;
    idle_check("midreset_hold");

    // simultaneous requests straight after reset: D first
    do_reset();
    push_burst(1'b1, 1'b0, 32'h300);
    push_burst(1'b0, 1'b0, 32'h500);
    d_addr = 32'h300;
    d_we   = 1'b0;
    i_addr = 32'h500;
    d_req  = 1'b1;
    i_req  = 1'b1;
    wait_done(got_d, c1);
    chk("tie_first_is_d", {31'b0, got_d}, 32'h1);
    chk("tie_first_cycle", c1, 5);
    d_req = 1'b0;
    wait_done(got_d, c2);
    i_req = 1'b0;
    chk("tie_second_is_i", {31'b0, got_d}, 32'h0);
    chk("tie_second_cycle", c1 + c2, 11);

    // both requesters re-request every burst
    do_reset();
    last_d = 1'b0;
    d_addr = 32'h300;
    d_we   = 1'b0;
    i_addr = 32'h500;
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
`ifdef ARB_RR_EN
      exp_own_d = !last_d;
`else
      exp_own_d = 1'b1;
`endif
      last_d = exp_own_d;
      push_burst(exp_own_d, 1'b0, exp_own_d ? 32'h300 : 32'h500);
      d_req = 1'b1;
      i_req = 1'b1;
      wait_done(got_d, cyc);
      chk($sformatf("rr%0d_owner", b), {31'b0, got_d}, {31'b0, exp_own_d});
      chk($sformatf("rr%0d_cycle", b), cyc, 5);
      if (got_d) d_req = 1'b0;
      else i_req = 1'b0;
    end
    @(negedge clk);
    d_req = 1'b0;
    i_req = 1'b0;
    repeat (3) @(negedge clk);
    #3;
    chk("leftover_beats", exp_beat.size(), 0);
    chk("leftover_i", exp_i.size(), 0);
    chk("leftover_d", exp_d.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sits between the instruction cache, the data cache and the single main-memory port of the cached CPU.
- Grants the memory port to one cache at a time for whole-block bursts: I-cache refills, and D-cache refills or writebacks.
- Sequences each burst beat by beat against a memory with variable latency (ready handshake).
- Returns the read beats and a completion pulse to the owning cache.

Parameters:
- DW, 32, data word width.
- AW, 32, word-address width.
- BLOCK_WORDS, 4, words per cache block; must be a power of two, at least 2. OFF = log2(BLOCK_WORDS) is derived.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_req  in  1  I-cache burst request; held high until i_done
- i_addr  in  AW  I-cache block word address; low OFF bits ignored; stable while i_req is high
- i_rdata  out  DW  read beat to I-cache
- i_valid  out  1  i_rdata valid, one cycle per beat
- i_done  out  1  one-cycle pulse when the I-cache burst completes
- d_req  in  1  D-cache burst request; held high until d_done
- d_we  in  1  1 = writeback burst, 0 = refill; stable while d_req is high
- d_addr  in  AW  D-cache block word address; same rules as i_addr
- d_wdata  in  DW  write word for the current beat, selected by the D-cache from beat_idx
- d_rdata  out  DW  read beat to D-cache
- d_valid  out  1  d_rdata valid
- d_done  out  1  one-cycle pulse when the D-cache burst completes
- beat_idx  out  OFF  current beat number of the active burst
- mem_en  out  1  memory access active
- mem_we  out  1  memory write
- mem_addr  out  AW  memory word address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data
- mem_ready  in  1  beat completes in a cycle where mem_en && mem_ready

Behaviour:
- Reset: state = IDLE, beat_idx = 0, owner = D, rr_last = I. All outputs are 0.
- Reset applies in any state and aborts a burst mid-operation; mem_en = 0 in the cycle after the reset edge.
- State machine IDLE -> BUSY -> DONE -> IDLE.
- IDLE:
  - mem_en = 0.
  - If any request is high, latch the owner per the arbitration policy, clear beat_idx and go to BUSY.
  - Grant latency is 1 cycle: mem_en is high in the cycle after the request is first seen.
- BUSY, outputs:
  - mem_en = 1 on every cycle.
  - mem_addr = {owner_addr[AW-1:OFF], beat_idx}.
  - mem_we = (owner == D) && d_we.
  - mem_wdata = d_wdata, combinational passthrough.
- BUSY, on mem_en && mem_ready:
  - Read burst: register mem_rdata into the owner's rdata and pulse the owner's valid in the next cycle.
  - If beat_idx == BLOCK_WORDS-1, go to DONE. Otherwise increment beat_idx.
- BUSY, stall: mem_ready = 0 holds mem_addr, beat_idx and mem_wdata selection unchanged, with no limit on stall length.
- DONE:
  - mem_en = 0.
  - Owner's done = 1. For a read burst, the last beat's valid is high in the same cycle.
  - Then go to IDLE.
- Requests are ignored in the DONE cycle. The requester must drop req at the edge ending DONE; a req still high in IDLE is treated as a new burst.
- The non-owner's valid and done stay 0 for the whole burst.
- A request arriving during another burst waits; there is no preemption.
- rdata outputs hold their last value when not valid.
- Address wrap: the beat counter wraps only within the block. The upper bits are never incremented.
- Default arbitration (fixed priority): when both requests are high in IDLE, D wins.

Optional Feature:
- Macro: ARB_RR_EN.
- Defined: round-robin. On a tie in IDLE, the grant goes to the requester that was not granted last (rr_last is updated at each grant). A lone requester is always granted.
- Undefined: fixed D-over-I priority; rr_last is not implemented.

Test Plan:
- Reset: hold rst 2 cycles mid-burst (beat_idx = 2) -> next cycle state IDLE, mem_en = 0, beat_idx = 0, all valid/done = 0.
- I refill, BLOCK_WORDS = 4, mem_ready = 1, i_addr = 0x45:
  - mem_addr = 0x44, 0x45, 0x46, 0x47 on consecutive cycles.
  - mem_rdata = 0xA0..0xA3 -> i_valid on 4 consecutive cycles with 0xA0..0xA3.
  - i_done coincides with the 0xA3 beat.
- D writeback, d_addr = 0x100, d_wdata = 0xD0 + beat_idx:
  - mem_we = 1 and mem_wdata = 0xD0..0xD3 at addresses 0x100..0x103.
  - d_valid never asserted; d_done pulses once.
- Stall: mem_ready low for 3 cycles on beat 1 -> mem_addr holds 0x101 for 4 cycles, and the burst completes 3 cycles later than the unstalled case.
- Simultaneous i_req/d_req, ARB_RR_EN undefined -> D burst first; I is granted in the IDLE cycle after d_done.
- ARB_RR_EN defined, both requesters re-request continuously for 4 bursts -> grant order D, I, D, I.
